// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-output bundle between a pattern source and serial_pattern_tx.
// The master side requests jobs and observes the line; the slave side is the transmitter.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic             ready;
  logic             j;
  logic             active;
  logic             done;

  modport master (
    output start, pattern, reps,
    input  ready, j, active, done
  );

  modport slave (
    input  start, pattern, reps,
    output ready, j, active, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Bit-serial pattern transmitter: sends a latched pattern MSB-first, reps times,
// with GAP zero cycles between repetitions, then pulses done for one cycle.
//
// state   | meaning
// IDLE    | ready for a job, line low
// SHIFT   | a pattern bit is on j
// GAP     | zero-fill between repetitions
// DONE    | one-cycle end-of-job pulse
module serial_pattern_tx #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic                clk,
  input  logic                rst,
  serial_pattern_tx_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] rep_q,   rep_d;
  logic [GAP_W-1:0] gap_q,   gap_d;
  logic             j_q,     j_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.pattern;
          rep_d   = bus.reps;
          idx_d   = IDX_TOP;
          state_d = (bus.reps == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (idx_q == '0) begin
          rep_d = rep_q - REP_ONE;
          idx_d = IDX_TOP;
          if (rep_q == REP_ONE) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_TOP;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_SHIFT;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // j is registered from the next state so the line never sees input glitches.
  assign j_d = (state_d == S_SHIFT) && shreg_d[idx_d];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      j_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      j_q     <= j_d;
    end
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.active = (state_q == S_SHIFT);
  assign bus.done   = (state_q == S_DONE);
  assign bus.j      = j_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: a GAP=0 and a GAP=2 instance, expected
// per-cycle {ready,done,active,j} words queued at accept and popped on each falling edge.
module tb_serial_pattern_tx;
  localparam int WIDTH = 5;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if0 ();
  serial_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if2 ();

  serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  logic [3:0] q0[$];
  logic [3:0] q2[$];
  int det_hits = 0;
  logic [4:0] det_sh = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int inst, input logic [3:0] e);
    if (inst == 0) q0.push_back(e);
    else           q2.push_back(e);
  endtask

  // Expected words: {ready, done, active, j}
  task automatic push_job(input int inst, input logic [WIDTH-1:0] pat,
                          input logic [CNT_W-1:0] reps, input int gap);
    for (int r = 0; r < int'(reps); r++) begin
      for (int b = WIDTH - 1; b >= 0; b--) push(inst, {3'b001, pat[b]});
      if (r < int'(reps) - 1)
        for (int g = 0; g < gap; g++) push(inst, 4'b0000);
    end
    push(inst, 4'b0100);
    push(inst, 4'b1000);
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) chk("dut0_cycle", int'({if0.ready, if0.done, if0.active, if0.j}), int'(q0.pop_front()));
    else if (mon_en)   chk("dut0_idle",  int'({if0.ready, if0.done, if0.active, if0.j}), int'(4'b1000));
    if (q2.size() > 0) chk("dut2_cycle", int'({if2.ready, if2.done, if2.active, if2.j}), int'(q2.pop_front()));
    else if (mon_en)   chk("dut2_idle",  int'({if2.ready, if2.done, if2.active, if2.j}), int'(4'b1000));
  end

  // 10110 detector loopback on the GAP=0 line
  always @(negedge clk) begin
    if (mon_en) begin
      det_sh = {det_sh[3:0], if0.j};
      if (det_sh == 5'b10110) det_hits++;
    end
  end

  task automatic run_job(input int inst, input logic [WIDTH-1:0] pat,
                         input logic [CNT_W-1:0] reps, input int gap,
                         input bit scramble, input bit busy);
    int left;
    @(negedge clk);
    if (inst == 0) begin if0.start = 1'b1; if0.pattern = pat; if0.reps = reps; end
    else           begin if2.start = 1'b1; if2.pattern = pat; if2.reps = reps; end
    @(posedge clk);
    push_job(inst, pat, reps, gap);
    #1;
    if0.start = 1'b0;
    if2.start = 1'b0;
    left = 1;
    for (int c = 0; c < 200 && left > 0; c++) begin
      @(negedge clk);
      if (scramble) begin
        if0.pattern = WIDTH'($urandom);
        if0.reps    = CNT_W'($urandom);
      end
      if (busy && c == 3) begin
        if0.start = 1'b1; if0.pattern = 5'b11111; if0.reps = 4'd7;
      end else if (busy && c == 4) begin
        if0.start = 1'b0;
      end
      #1;
      left = (inst == 0) ? q0.size() : q2.size();
    end
    chk("job_drained", left, 0);
  endtask

  initial begin
    if0.start = 1'b0; if0.pattern = '0; if0.reps = '0;
    if2.start = 1'b0; if2.pattern = '0; if2.reps = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    det_hits = 0;
    run_job(0, 5'b10110, 4'd1, 0, 1'b0, 1'b0);
    chk("detector_hits", det_hits, 1);

    run_job(0, 5'b10110, 4'd3, 0, 1'b0, 1'b0);
    run_job(2, 5'b10110, 4'd3, 2, 1'b0, 1'b0);
    run_job(0, 5'b10110, 4'd0, 0, 1'b0, 1'b0);
    run_job(0, 5'b10110, 4'd2, 0, 1'b0, 1'b1);
    run_job(0, 5'b01101, 4'd3, 0, 1'b1, 1'b0);
    run_job(2, 5'b10011, 4'd2, 2, 1'b0, 1'b0);

    // Abort a reps=2 job after its third bit: no done, idle next cycle.
    @(negedge clk);
    if0.start = 1'b1; if0.pattern = 5'b10110; if0.reps = 4'd2;
    @(posedge clk);
    q0.push_back(4'b0011);
    q0.push_back(4'b0010);
    q0.push_back(4'b0011);
    q0.push_back(4'b1000);
    #1 if0.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1 chk("abort_drained", q0.size(), 0);

    run_job(0, 5'b11001, 4'd1, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
